// File: rtl/vending_pkg.sv
// Shared constants and enums for the vending front end: coin values,
// emit-FSM states and per-channel indices.
package vending_pkg;

    localparam int NICKEL_VAL = 5;
    localparam int DIME_VAL   = 10;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        GAP
    } emit_state_e;

    typedef enum logic [1:0] {
        CH_NICKEL,
        CH_DIME,
        CH_REFUND
    } channel_e;

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser, debounce counter and registered rising-edge pulse
// for one raw sensor/button level.
module debounce_sync
    import vending_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_q, rise_d;

    always_comb begin
        s1_d     = raw;
        s2_d     = s1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        // The edge that would bring the count to DEBOUNCE_CYCLES flips stable instead.
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        rise_d = stable_d & ~stable_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin/refund front end: debounced channels feed pending flags and a
// three-state emit FSM. Optional totals enabled by COIN_ACCEPTOR_STATS_EN.
module coin_acceptor
    import vending_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             nickel_raw,
    input  logic             dime_raw,
    input  logic             refund_raw,
    input  logic             accept_en,
    output logic             nickel,
    output logic             dime,
    output logic             refund,
    output logic             coin_jam,
    output logic [CNT_W-1:0] nickel_total,
    output logic [CNT_W-1:0] dime_total
);

    logic [2:0]  rise;
    logic [2:0]  pending_q, pending_d;
    logic [2:0]  clr;
    emit_state_e state_q, state_d;
    logic        nickel_q, nickel_d;
    logic        dime_q, dime_d;
    logic        refund_q, refund_d;
    logic        jam_q, jam_d;

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_nickel (
        .clk(clk), .reset_n(reset_n), .raw(nickel_raw), .rise(rise[CH_NICKEL])
    );
    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dime (
        .clk(clk), .reset_n(reset_n), .raw(dime_raw), .rise(rise[CH_DIME])
    );
    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_refund (
        .clk(clk), .reset_n(reset_n), .raw(refund_raw), .rise(rise[CH_REFUND])
    );

    always_comb begin
        state_d  = state_q;
        clr      = 3'b000;
        nickel_d = 1'b0;
        dime_d   = 1'b0;
        refund_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_en && (|pending_q)) begin
                    state_d = EMIT;
                    if (pending_q[CH_NICKEL]) begin
                        nickel_d       = 1'b1;
                        clr[CH_NICKEL] = 1'b1;
                    end else if (pending_q[CH_DIME]) begin
                        dime_d       = 1'b1;
                        clr[CH_DIME] = 1'b1;
                    end else begin
                        refund_d       = 1'b1;
                        clr[CH_REFUND] = 1'b1;
                    end
                end
            end
            EMIT:    state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A rise on the edge its channel is consumed re-arms it rather than jamming.
        pending_d = (pending_q & ~clr) | rise;
        jam_d     = jam_q | (|(rise & pending_q & ~clr));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pending_q <= 3'b000;
            nickel_q  <= 1'b0;
            dime_q    <= 1'b0;
            refund_q  <= 1'b0;
            jam_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            nickel_q  <= nickel_d;
            dime_q    <= dime_d;
            refund_q  <= refund_d;
            jam_q     <= jam_d;
        end
    end

    assign nickel   = nickel_q;
    assign dime     = dime_q;
    assign refund   = refund_q;
    assign coin_jam = jam_q;

`ifdef COIN_ACCEPTOR_STATS_EN
    logic [CNT_W-1:0] nickel_total_q, nickel_total_d;
    logic [CNT_W-1:0] dime_total_q, dime_total_d;

    always_comb begin
        nickel_total_d = nickel_total_q;
        dime_total_d   = dime_total_q;
        // Saturating: counts stick at all-ones.
        if (nickel_d && (nickel_total_q != '1)) nickel_total_d = nickel_total_q + 1'b1;
        if (dime_d && (dime_total_q != '1))     dime_total_d   = dime_total_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            nickel_total_q <= '0;
            dime_total_q   <= '0;
        end else begin
            nickel_total_q <= nickel_total_d;
            dime_total_q   <= dime_total_d;
        end
    end

    assign nickel_total = nickel_total_q;
    assign dime_total   = dime_total_q;
`else
    assign nickel_total = '0;
    assign dime_total   = '0;
`endif

endmodule
